sd_cmd_seq: RTL and testbench
=============================

SD_CMD_SEQ -- requirements
Module: sd_cmd_seq

Interface
- REQ-001: Parameter CRC_TIMEOUT, default 16, is the maximum number of clk_i cycles to wait in CRC_WAIT for crc_valid_i.
- REQ-002: clk_i  input  1  single clock; all state changes on rising edge.
- REQ-003: rst_ni  input  1  asynchronous, active-low reset.
- REQ-004: start_i  input  1  command request; accepted only when start_i=1 and ready_o=1 in the same cycle.
- REQ-005: cmd_index_i  input  6  command index, sampled on acceptance.
- REQ-006: cmd_arg_i  input  32  command argument, sampled on acceptance.
- REQ-007: abort_i  input  1  synchronous abort.
- REQ-008: tick_i  input  1  SD bit strobe; advances the CMD line by one bit.
- REQ-009: ready_o  output  1  high only in IDLE.
- REQ-010: done_o  output  1  one-cycle pulse when a frame has fully shifted out.
- REQ-011: err_o  output  1  one-cycle pulse on CRC timeout.
- REQ-012: crc_en_o  output  1  one-cycle request to the external crc7 engine.
- REQ-013: crc_data_o  output  40  {1'b0, 1'b1, index, arg}; held stable from CRC_REQ through CRC_WAIT.
- REQ-014: crc_i  input  7  CRC result from the crc7 engine.
- REQ-015: crc_valid_i  input  1  crc_i is valid in this cycle.
- REQ-016: cmd_o  output  1  CMD line data; 1 whenever cmd_oe_o=0.
- REQ-017: cmd_oe_o  output  1  CMD line drive enable; high only in SHIFT.

Function
- REQ-018: FSM states SHALL be IDLE, CRC_REQ, CRC_WAIT, SHIFT, DONE.
- REQ-019: IDLE -> CRC_REQ on accept; index and arg latched; the 40-bit prefix is formed at this point.
- REQ-020: CRC_REQ SHALL assert crc_en_o for exactly one cycle, then go to CRC_WAIT unconditionally.
- REQ-021: CRC_WAIT with crc_valid_i=1 SHALL latch crc_i and load the 48-bit shift register {prefix, crc, 1'b1}; bit counter = 47; next state SHIFT.
- REQ-022: CRC_WAIT SHALL count cycles; if CRC_TIMEOUT cycles elapse without crc_valid_i, it goes to IDLE and pulses err_o.
- REQ-023: If crc_valid_i and timeout expiry occur in the same cycle, valid wins (SHIFT, no err_o).
- REQ-024: In SHIFT, cmd_o = shift_reg[47] and cmd_oe_o = 1; the first bit (start bit 0) SHALL be driven in the first SHIFT cycle.
- REQ-025: On tick_i in SHIFT with counter > 0, the register shifts left by one and the counter decrements.
- REQ-026: On tick_i in SHIFT with counter = 0 (end bit), the block goes to DONE; 48 ticks total are consumed per frame.
- REQ-027: DONE SHALL pulse done_o for one cycle with cmd_oe_o=0 and cmd_o=1, then go to IDLE.
- REQ-028: tick_i outside SHIFT SHALL be ignored; start_i while ready_o=0 SHALL be ignored (no queueing).
- REQ-029: abort_i=1 in any non-IDLE state SHALL force IDLE on the next edge, with cmd_oe_o=0, no done_o and no err_o; abort_i has priority over all other events.
- REQ-030: Minimum frame latency from accept to done_o = 1 (CRC_REQ) + CRC wait + 48 ticks + 1 cycle.

Reset
- REQ-031: While rst_ni=0, outputs SHALL be: ready_o=1, cmd_o=1, cmd_oe_o=0, done_o=0, err_o=0, crc_en_o=0, crc_data_o=0; state IDLE; counters 0.
- REQ-032: Reset asserted mid-frame SHALL drop cmd_oe_o immediately (asynchronously); no pulses are issued on reset release.

Verification
- REQ-033: CMD0 with arg 0x00000000 and a crc7 model -> crc_data_o=0x4000000000, crc 0x4A, 48 cmd_o bits = 0x400000000095, then one done_o pulse.
- REQ-034: CMD8 with arg 0x000001AA -> crc 0x43, serialized frame 0x48000001AA87; ready_o returns 1 the cycle after done_o.
- REQ-035: CMD17 with arg 0, tick_i every 4 cycles -> frame 0x510000000055, each bit held for 4 cycles, cmd_oe_o high for exactly 48 tick intervals.
- REQ-036: crc_valid_i withheld -> err_o pulses after exactly 16 CRC_WAIT cycles, cmd_oe_o never rises, ready_o=1 the next cycle; crc_valid_i at the 16th cycle -> SHIFT, no err_o.
- REQ-037: abort_i after 20 ticks of SHIFT -> cmd_oe_o=0 and cmd_o=1 on the next edge, no done_o; a new start is accepted afterwards and its frame is correct.
- REQ-038: rst_ni pulsed low mid-SHIFT -> cmd_oe_o low without a clock edge; all outputs at REQ-031 values.

Source files
------------

// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq -- SD card command-line sequencer.
//
// Accepts one command (index + argument). It asks an external crc7 engine
// for the CRC of the 40-bit prefix {0, 1, index, arg}. It then serialises
// the 48-bit frame {prefix, crc7, 1} MSB first on the CMD line, one bit per
// tick_i strobe.
//
// Ports
//   clk_i        in   clock, all state changes on the rising edge
//   rst_ni       in   asynchronous active-low reset
//   start_i      in   command request, taken when start_i & ready_o
//   cmd_index_i  in   [5:0]  command index, sampled on acceptance
//   cmd_arg_i    in   [31:0] command argument, sampled on acceptance
//   abort_i      in   synchronous abort, returns to IDLE from any busy state
//   tick_i       in   SD bit strobe, only meaningful while shifting
//   ready_o      out  high only in IDLE
//   done_o       out  one-cycle pulse after the end bit has been shifted
//   err_o        out  one-cycle pulse when the CRC engine times out
//   crc_en_o     out  one-cycle request to the crc7 engine
//   crc_data_o   out  [39:0] prefix presented to the crc7 engine
//   crc_i        in   [6:0]  crc7 result
//   crc_valid_i  in   crc_i valid this cycle
//   cmd_o        out  CMD line data, 1 whenever not driving
//   cmd_oe_o     out  CMD line drive enable, high only while shifting
//   dbg_state_o  out  [2:0] current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where start_i=1 and
// ready_o=1. start_i is ignored while ready_o=0 and is never queued.
// crc_i is consumed on the first edge in CRC_WAIT where crc_valid_i=1.
module sd_cmd_seq #(
   parameter int CRC_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [5:0]  cmd_index_i,
   input  logic [31:0] cmd_arg_i,
   input  logic        abort_i,
   input  logic        tick_i,
   output logic        ready_o,
   output logic        done_o,
   output logic        err_o,
   output logic        crc_en_o,
   output logic [39:0] crc_data_o,
   input  logic [6:0]  crc_i,
   input  logic        crc_valid_i,
   output logic        cmd_o,
   output logic        cmd_oe_o,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CRC_REQ  = 3'd1,
      S_CRC_WAIT = 3'd2,
      S_SHIFT    = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   localparam int TW = $clog2(CRC_TIMEOUT + 1);
   // Last CRC_WAIT cycle index before the timeout fires.
   localparam logic [TW-1:0] WAIT_LAST = TW'(CRC_TIMEOUT - 1);

   state_t        r_state;
   logic [39:0]   r_prefix;
   logic [47:0]   r_shift;
   logic [5:0]    r_bit_cnt;
   logic [TW-1:0] r_wait_cnt;
   logic          r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_prefix   <= '0;
         r_shift    <= '1;
         r_bit_cnt  <= '0;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= 1'b0;
         // Abort beats every other event, including a same-cycle timeout.
         if (abort_i && (r_state != S_IDLE)) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start_i) begin
                     r_prefix <= {1'b0, 1'b1, cmd_index_i, cmd_arg_i};
                     r_state  <= S_CRC_REQ;
                  end
               end
               S_CRC_REQ: begin
                  r_wait_cnt <= '0;
                  r_state    <= S_CRC_WAIT;
               end
               S_CRC_WAIT: begin
                  // Valid is checked first so it wins over expiry.
                  if (crc_valid_i) begin
                     r_shift    <= {r_prefix, crc_i, 1'b1};
                     r_bit_cnt  <= 6'd47;
                     r_wait_cnt <= '0;
                     r_state    <= S_SHIFT;
                  end else if (r_wait_cnt == WAIT_LAST) begin
                     r_wait_cnt <= '0;
                     r_err      <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + TW'(1);
                  end
               end
               S_SHIFT: begin
                  if (tick_i) begin
                     if (r_bit_cnt != 6'd0) begin
                        r_shift   <= {r_shift[46:0], 1'b1};
                        r_bit_cnt <= r_bit_cnt - 6'd1;
                     end else begin
                        r_state <= S_DONE;
                     end
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Outputs are pure decodes of registers, so an asynchronous reset
   // releases the CMD line at once without waiting for a clock edge.
   assign ready_o     = (r_state == S_IDLE);
   assign done_o      = (r_state == S_DONE);
   assign crc_en_o    = (r_state == S_CRC_REQ);
   assign err_o       = r_err;
   assign cmd_oe_o    = (r_state == S_SHIFT);
   assign cmd_o       = cmd_oe_o ? r_shift[47] : 1'b1;
   assign crc_data_o  = r_prefix;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Bench for sd_cmd_seq: directed steps plus randomized frames. A crc7
// model answers the CRC requests. The expected frame is built from the
// frame format and pushed onto a scoreboard queue.
module tb_sd_cmd_seq;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        start_i = 1'b0;
   logic [5:0]  cmd_index_i = '0;
   logic [31:0] cmd_arg_i = '0;
   logic        abort_i = 1'b0;
   logic        tick_i = 1'b0;
   logic        ready_o, done_o, err_o, crc_en_o, cmd_o, cmd_oe_o;
   logic [39:0] crc_data_o;
   logic [6:0]  crc_i = '0;
   logic        crc_valid_i = 1'b0;
   logic [2:0]  dbg_state_o;

   sd_cmd_seq #(.CRC_TIMEOUT(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .abort_i(abort_i),
      .tick_i(tick_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
      .crc_en_o(crc_en_o), .crc_data_o(crc_data_o), .crc_i(crc_i),
      .crc_valid_i(crc_valid_i), .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- scoreboard ----------------
   logic [47:0] exp_q[$];
   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // crc7, polynomial x^7 + x^3 + 1, MSB first, zero initial value
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] p;
      p = {2'b01, idx, arg};
      return {p, crc7(p), 1'b1};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_ready();
      int n;
      n = 0;
      while (ready_o !== 1'b1 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 200) chk("ready_timeout", 64'(ready_o), 64'd1);
   endtask

   // Ends at the negedge of the CRC_REQ cycle.
   task automatic do_accept(input logic [5:0] idx, input logic [31:0] arg,
                            output logic [39:0] seen_data);
      wait_ready();
      start_i = 1'b1;
      cmd_index_i = idx;
      cmd_arg_i = arg;
      @(negedge clk_i);
      start_i = 1'b0;
      cmd_index_i = 6'($urandom);
      cmd_arg_i = $urandom;
      chk("crc_en_req", 64'(crc_en_o), 64'd1);
      chk("crc_data_req", 64'(crc_data_o), 64'({2'b01, idx, arg}));
      chk("ready_busy", 64'(ready_o), 64'd0);
      seen_data = crc_data_o;
      tick_i = 1'($urandom);
   endtask

   // Valid arrives in CRC_WAIT cycle delay+1; ends at first SHIFT negedge.
   task automatic do_crc(input logic [39:0] prefix, input int delay);
      for (int w = 0; w <= delay; w++) begin
         @(negedge clk_i);
         tick_i = 1'($urandom);
         crc_i = 7'($urandom);
         if (crc_en_o !== 1'b0 || err_o !== 1'b0 || cmd_oe_o !== 1'b0 || crc_data_o !== prefix)
            chk("crc_wait_outputs", {crc_en_o, err_o, cmd_oe_o, 1'b0}, 64'd0);
         if (w == delay) begin
            crc_valid_i = 1'b1;
            crc_i = crc7(prefix);
         end
      end
      @(negedge clk_i);
      crc_valid_i = 1'b0;
      tick_i = 1'b0;
   endtask

   // Each bit is held for per cycles, tick in the last cycle of the period.
   task automatic do_ticks(input int n, input int per, output logic [47:0] bits,
                           output int oe_cnt, output bit hold_ok);
      logic cur;
      bits = '0;
      oe_cnt = 0;
      hold_ok = 1'b1;
      cur = 1'b0;
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c < per; c++) begin
            if (cmd_oe_o === 1'b1) oe_cnt++;
            if (c == 0) cur = cmd_o;
            else if (cmd_o !== cur) hold_ok = 1'b0;
            tick_i = (c == per - 1);
            start_i = ($urandom_range(0, 3) == 0);
            @(negedge clk_i);
         end
         bits = {bits[46:0], cur};
      end
      tick_i = 1'b0;
      start_i = 1'b0;
   endtask

   task automatic check_done(input string tag);
      chk({tag, "_done"}, 64'(done_o), 64'd1);
      chk({tag, "_done_oe"}, {cmd_oe_o, cmd_o}, 64'b01);
      chk({tag, "_done_ready"}, 64'(ready_o), 64'd0);
      @(negedge clk_i);
      chk({tag, "_after_done"}, {ready_o, done_o, crc_en_o}, 64'b100);
   endtask

   task automatic run_frame(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                            input int delay, input int per, output logic [47:0] got,
                            output logic [39:0] seen);
      int oe_cnt;
      bit hold_ok;
      logic [47:0] exp;
      exp_q.push_back(frame_of(idx, arg));
      do_accept(idx, arg, seen);
      do_crc({2'b01, idx, arg}, delay);
      do_ticks(48, per, got, oe_cnt, hold_ok);
      exp = exp_q.pop_front();
      chk({tag, "_frame"}, 64'(got), 64'(exp));
      chk({tag, "_oe_cycles"}, 64'(oe_cnt), 64'(48 * per));
      chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
      check_done(tag);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [47:0] got;
      logic [39:0] seen;
      int oe_cnt;
      bit hold_ok;
      logic [5:0] ridx;
      logic [31:0] rarg;

      // reset values
      @(negedge clk_i);
      @(negedge clk_i);
      chk("rst_outputs", {ready_o, cmd_o, cmd_oe_o, done_o, err_o, crc_en_o}, 64'b110000);
      chk("rst_crc_data", 64'(crc_data_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // CMD0, arg 0, one tick per cycle
      run_frame("cmd0", 6'd0, 32'h0, 0, 1, got, seen);
      chk("cmd0_crc_data", 64'(seen), 64'h40_0000_0000);
      chk("cmd0_const", 64'(got), 64'h4000_0000_0095);

      // CMD8, arg 0x1AA, tick every 2 cycles
      run_frame("cmd8", 6'd8, 32'h1AA, 3, 2, got, seen);
      chk("cmd8_const", 64'(got), 64'h4800_0001_AA87);

      // CMD17, arg 0, tick every 4 cycles
      run_frame("cmd17", 6'd17, 32'h0, 1, 4, got, seen);
      chk("cmd17_const", 64'(got), 64'h5100_0000_0055);

      // CRC timeout: 16 wait cycles without valid
      do_accept(6'd2, 32'h1234, seen);
      for (int w = 0; w < 16; w++) begin
         @(negedge clk_i);
         if (err_o !== 1'b0 || cmd_oe_o !== 1'b0)
            chk("tmo_early", {err_o, cmd_oe_o}, 64'd0);
      end
      @(negedge clk_i);
      chk("tmo_err", {err_o, ready_o, cmd_oe_o}, 64'b110);
      @(negedge clk_i);
      chk("tmo_err_pulse", {err_o, ready_o}, 64'b01);

      // valid in the 16th wait cycle wins over expiry
      run_frame("late_valid", 6'd55, 32'hDEAD_BEEF, 15, 1, got, seen);
      chk("late_valid_no_err", 64'(err_o), 64'd0);

      // abort after 20 ticks
      do_accept(6'd9, 32'hCAFE_0001, seen);
      do_crc({2'b01, 6'd9, 32'hCAFE_0001}, 2);
      do_ticks(20, 1, got, oe_cnt, hold_ok);
      chk("abort_partial", 64'(got[19:0]), 64'(frame_of(6'd9, 32'hCAFE_0001) >> 28));
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      chk("abort_line", {cmd_oe_o, cmd_o, ready_o, done_o, err_o}, 64'b01100);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (done_o !== 1'b0 || err_o !== 1'b0) chk("abort_no_pulse", {done_o, err_o}, 64'd0);
      end
      ridx = 6'($urandom);
      rarg = $urandom;
      run_frame("post_abort", ridx, rarg, 0, 1, got, seen);

      // randomized frames
      for (int r = 0; r < 6; r++) begin
         ridx = 6'($urandom);
         rarg = $urandom;
         run_frame("rand", ridx, rarg, $urandom_range(0, 15), $urandom_range(1, 3), got, seen);
      end

      // asynchronous reset in the middle of SHIFT
      do_accept(6'd41, 32'h0F0F_F0F0, seen);
      do_crc({2'b01, 6'd41, 32'h0F0F_F0F0}, 1);
      do_ticks(10, 1, got, oe_cnt, hold_ok);
      chk("mid_oe_before", 64'(cmd_oe_o), 64'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_outputs", {ready_o, cmd_o, cmd_oe_o, done_o, err_o, crc_en_o}, 64'b110000);
      chk("rst_mid_crc_data", 64'(crc_data_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (done_o !== 1'b0 || err_o !== 1'b0 || crc_en_o !== 1'b0 || ready_o !== 1'b1)
            chk("rst_release_quiet", {ready_o, done_o, err_o, crc_en_o}, 64'b1000);
      end
      chk("rst_release_ready", 64'(ready_o), 64'd1);
      run_frame("post_rst", 6'd12, 32'h8000_0001, 4, 2, got, seen);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
